// File: rtl/irq_ctrl.sv
// Interrupt controller for the CP0 interrupt[5:0] input: pin sync, edge/level pend,
// masking, single-level in-service tracking. Optional timer on source 5 with IRQ_TIMER_EN.

// One interrupt source: 2-flop sync, edge detect and pending state.
module irq_src (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic mode,
  input  logic timer_src,
  input  logic tmr_hit,
  input  logic w1c,
  output logic pend
);
  logic s1, s2, s3, rise_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
      pend   <= 1'b0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      s3     <= s2;
      // rise strobe is registered so an edge source lands one cycle after a level one
      rise_q <= s2 & ~s3;
      if (timer_src)
        pend <= tmr_hit | (pend & ~w1c);
      else if (mode)
        pend <= rise_q | (pend & ~w1c);
      else
        pend <= s2;
    end
  end
endmodule

module irq_ctrl #(
  parameter int NSRC  = 6,
  parameter int TMR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_pin,
  input  logic            exl,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [NSRC-1:0] interrupt,
  output logic [2:0]      irq_id
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] INSRV = 1'b1;

`ifdef IRQ_TIMER_EN
  localparam logic [NSRC-1:0] TSRC = {1'b1, {(NSRC-1){1'b0}}};
`else
  localparam logic [NSRC-1:0] TSRC = '0;
`endif

  logic [NSRC-1:0] mode, mask, pend, act, prio_ok, w1c;
  logic [0:0]      state;
  logic [2:0]      isr_id;
  logic            isr_valid, exl_q, tmr_hit;
  logic            pend_wr, stat_wr;

  assign pend_wr   = we && (addr == 3'd2);
  assign stat_wr   = we && (addr == 3'd3);
  assign w1c       = pend_wr ? wd[NSRC-1:0] : '0;
  assign isr_valid = (state == INSRV);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_src u_src (
      .clk       (clk),
      .rst       (rst),
      .pin       (irq_pin[i]),
      .mode      (mode[i]),
      .timer_src (TSRC[i]),
      .tmr_hit   (tmr_hit),
      .w1c       (w1c[i]),
      .pend      (pend[i])
    );
    assign prio_ok[i] = ~isr_valid | (3'(i) > isr_id);
  end

  assign act = pend & mask & prio_ok;

  // ascending scan: the highest active index is the last one written
  always_comb begin
    irq_id = 3'd7;
    for (int i = 0; i < NSRC; i++)
      if (act[i]) irq_id = 3'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= '0;
      mask      <= '0;
      exl_q     <= 1'b0;
      interrupt <= '0;
    end else begin
      if (we && addr == 3'd0) mode <= wd[NSRC-1:0];
      if (we && addr == 3'd1) mask <= wd[NSRC-1:0];
      exl_q     <= exl;
      interrupt <= act;
    end
  end

  // nesting depth 1: an exl rise while in service is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      isr_id <= 3'd0;
    end else begin
      case (state)
        IDLE: if (exl && !exl_q && irq_id != 3'd7) begin
          state  <= INSRV;
          isr_id <= irq_id;
        end
        INSRV: if (stat_wr || (pend_wr && wd[isr_id])) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_TIMER_EN
  logic [TMR_W-1:0] count, compare;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '1;
    end else begin
      if (we && addr == 3'd5) count <= TMR_W'(wd);
      else                    count <= count + TMR_W'(1);
      if (we && addr == 3'd4) compare <= TMR_W'(wd);
    end
  end

  assign tmr_hit = (count == compare);
`else
  assign tmr_hit = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (addr)
      3'd0: rd = 32'(mode);
      3'd1: rd = 32'(mask);
      3'd2: rd = 32'(pend);
      3'd3: rd = {28'd0, isr_valid, isr_id};
`ifdef IRQ_TIMER_EN
      3'd4: rd = 32'(compare);
      3'd5: rd = 32'(count);
`endif
      default: rd = '0;
    endcase
  end

  logic unused_wd;
  assign unused_wd = &{1'b0, wd[31:NSRC], TMR_W > 0};
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, W1C, priority/in-service, masking, async reset,
// and the timer source when IRQ_TIMER_EN is defined.
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_pin;
  logic        exl, we;
  logic [2:0]  addr;
  logic [31:0] wd, rd;
  logic [5:0]  interrupt;
  logic [2:0]  irq_id;

  int checks = 0;
  int failures = 0;

`ifdef IRQ_TIMER_EN
  localparam logic [5:0] ALL = 6'h1F;
`else
  localparam logic [5:0] ALL = 6'h3F;
`endif

  irq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_pin   (irq_pin),
    .exl       (exl),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .interrupt (interrupt),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    tick(1);
    we = 1'b0; wd = '0;
  endtask

  task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    rst = 1'b0; irq_pin = '0; exl = 1'b0; we = 1'b0; addr = '0; wd = '0;
    tick(2);
    chk("rst_int", 32'(interrupt), 32'h0);
    chk("rst_id", 32'(irq_id), 32'd7);
    rchk("rst_mask", 3'd1, 32'h0);
    rst = 1'b1;
    tick(1);

    // level source latency: pend at N+2, interrupt at N+3
    wr(3'd1, 32'h3F);
    irq_pin = 6'h04;
    tick(3);
    chk("lvl_int_early", 32'(interrupt), 32'h0);
    chk("lvl_id", 32'(irq_id), 32'd2);
    tick(1);
    chk("lvl_int_rise", 32'(interrupt), 32'h04);
    tick(6);
    irq_pin = '0;
    tick(3);
    chk("lvl_int_hold", 32'(interrupt), 32'h04);
    chk("lvl_id_none", 32'(irq_id), 32'd7);
    tick(1);
    chk("lvl_int_fall", 32'(interrupt), 32'h0);

    // edge source held, W1C, set-beats-clear
    wr(3'd0, 32'h01);
    irq_pin = 6'h01;
    tick(1);
    irq_pin = '0;
    tick(2);
    rchk("edge_pend_early", 3'd2, 32'h0);
    tick(1);
    rchk("edge_pend_set", 3'd2, 32'h01);
    tick(5);
    rchk("edge_pend_held", 3'd2, 32'h01);
    wr(3'd2, 32'h01);
    rchk("edge_w1c", 3'd2, 32'h0);
    irq_pin = 6'h01;
    tick(1);
    irq_pin = '0;
    tick(2);
    wr(3'd2, 32'h01);
    rchk("set_wins", 3'd2, 32'h01);
    wr(3'd2, 32'h01);
    rchk("edge_w1c2", 3'd2, 32'h0);

    // priority and in-service
    wr(3'd0, 32'h32);
    irq_pin = 6'h12;
    tick(1);
    irq_pin = '0;
    tick(4);
    rchk("prio_pend", 3'd2, 32'h12);
    chk("prio_id", 32'(irq_id), 32'd4);
    chk("prio_int", 32'(interrupt), 32'h12);
    exl = 1'b1;
    tick(1);
    rchk("isr_stat", 3'd3, 32'h0C);
    chk("isr_id_none", 32'(irq_id), 32'd7);
    tick(1);
    chk("isr_int_masked", 32'(interrupt), 32'h0);
    exl = 1'b0;
    tick(1);
    exl = 1'b1;
    tick(1);
    rchk("nest_ignored", 3'd3, 32'h0C);
`ifndef IRQ_TIMER_EN
    irq_pin = 6'h20;
    tick(1);
    irq_pin = '0;
    tick(3);
    chk("isr_hi_id", 32'(irq_id), 32'd5);
    tick(1);
    chk("isr_hi_int", 32'(interrupt), 32'h20);
`endif
    wr(3'd2, 32'h10);
    rchk("isr_exit", 3'd3, 32'h04);
    tick(1);
    chk("isr_reassert", 32'(interrupt), 32'h22 & {ALL, 1'b0} >> 1 | 32'h02);
    wr(3'd2, 32'h3F);
    exl = 1'b0;
    tick(1);
    exl = 1'b1;
    tick(1);
    rchk("exl_no_src", 3'd3, 32'h04);
    exl = 1'b0;

    // masking, level W1C ignored, level->edge switch keeps pend
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0);
    irq_pin = 6'h3F;
    tick(3);
    rchk("mask0_pend", 3'd2, 32'(ALL));
    chk("mask0_int", 32'(interrupt), 32'h0);
    wr(3'd2, 32'h3F);
    rchk("lvl_w1c_ign", 3'd2, 32'(ALL));
    wr(3'd1, 32'h3F);
    chk("unmask_int0", 32'(interrupt), 32'h0);
    tick(1);
    chk("unmask_int1", 32'(interrupt), 32'(ALL));
    wr(3'd0, 32'h3F);
    tick(2);
    irq_pin = '0;
    tick(4);
    rchk("l2e_keep", 3'd2, 32'(ALL));
    wr(3'd2, 32'h3F);
    rchk("l2e_clear", 3'd2, 32'h0);

    // async reset mid-service
    wr(3'd0, 32'h08);
    irq_pin = 6'h08;
    tick(1);
    irq_pin = '0;
    tick(4);
    exl = 1'b1;
    tick(1);
    rchk("svc3_stat", 3'd3, 32'h0B);
    irq_pin = 6'h10;
    tick(4);
    chk("svc3_int", 32'(interrupt), 32'h10);
    chk("svc3_id", 32'(irq_id), 32'd4);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_int", 32'(interrupt), 32'h0);
    chk("arst_id", 32'(irq_id), 32'd7);
    chk("arst_stat", rd, 32'h0);
    exl = 1'b0;
    irq_pin = '0;
    tick(2);
    rst = 1'b1;
    tick(5);
    rchk("post_rst_stat", 3'd3, 32'h0);
    rchk("post_rst_mode", 3'd0, 32'h0);
    chk("post_rst_id", 32'(irq_id), 32'd7);

`ifdef IRQ_TIMER_EN
    wr(3'd4, 32'd20);
    wr(3'd5, 32'd0);
    wr(3'd2, 32'h20);
    wr(3'd1, 32'h20);
    tick(18);
    rchk("tmr_pend_early", 3'd2, 32'h0);
    tick(1);
    rchk("tmr_pend_set", 3'd2, 32'h20);
    chk("tmr_int_early", 32'(interrupt), 32'h0);
    tick(1);
    chk("tmr_int", 32'(interrupt), 32'h20);
    wr(3'd5, 32'hFFFF_FFFF);
    rchk("tmr_load", 3'd5, 32'hFFFF_FFFF);
    tick(1);
    chk("tmr_wrap", rd, 32'h0);
    rchk("tmr_pend_held", 3'd2, 32'h20);
`else
    wr(3'd4, 32'h1234);
    rchk("no_tmr_cmp", 3'd4, 32'h0);
    rchk("no_tmr_cnt", 3'd5, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
